// File: rtl/word_lexer_if.sv
// Character-in / token-out handshake bundle for word_lexer.
// The master side feeds characters and consumes tokens; the slave side is the lexer.
interface word_lexer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        tok_valid;
  logic [1:0]  tok_code;
  logic [7:0]  tok_len;
  logic        tok_last;
  logic        tok_ready;
  logic [15:0] word_count;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output tok_ready,
    input  in_ready,
    input  tok_valid,
    input  tok_code,
    input  tok_len,
    input  tok_last,
    input  word_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  tok_ready,
    output in_ready,
    output tok_valid,
    output tok_code,
    output tok_len,
    output tok_last,
    output word_count
  );
endinterface

// File: rtl/word_lexer.sv
// Streaming lexer: splits an ASCII stream into words and classifies each as BEGIN, END or OTHER.
// Define WORD_LEXER_PUNCT_SEP_EN to also treat ';' and ',' as separators.
module word_lexer (
  input logic        clk,
  input logic        reset,
  word_lexer_if.slave lex
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    B1   = 4'd1,
    B2   = 4'd2,
    B3   = 4'd3,
    B4   = 4'd4,
    B5   = 4'd5,
    E1   = 4'd6,
    E2   = 4'd7,
    E3   = 4'd8,
    OTH  = 4'd9
  } state_t;

  localparam logic [1:0] CODE_BEGIN = 2'b01;
  localparam logic [1:0] CODE_END   = 2'b10;
  localparam logic [1:0] CODE_OTHER = 2'b11;

  state_t      state_r;
  logic [7:0]  len_r;
  logic        tok_valid_r;
  logic [1:0]  tok_code_r;
  logic [7:0]  tok_len_r;
  logic        tok_last_r;
  logic [15:0] word_count_r;

  logic        in_ready_s;
  logic        accept_s;
  logic        sep_s;
  logic [7:0]  lc_s;
  state_t      adv_state_s;
  logic [7:0]  adv_len_s;
  logic        emit_s;
  logic [1:0]  emit_code_s;
  logic [7:0]  emit_len_s;
  logic        emit_last_s;
  state_t      nxt_state_s;
  logic [7:0]  nxt_len_s;

  function automatic logic is_sep(input logic [7:0] ch);
    logic r;
    case (ch)
      8'h20, 8'h09, 8'h0A, 8'h0D: r = 1'b1;
`ifdef WORD_LEXER_PUNCT_SEP_EN
      8'h3B, 8'h2C:               r = 1'b1;
`endif
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] ch);
    logic [7:0] r;
    if ((ch >= 8'h41) && (ch <= 8'h5A)) begin
      r = ch | 8'h20;
    end else begin
      r = ch;
    end
    return r;
  endfunction

  // Prefix walk over "begin"/"end"; any miss or overrun falls into OTH.
  function automatic state_t next_word_state(input state_t st, input logic [7:0] ch);
    state_t r;
    case (st)
      IDLE:    r = (ch == 8'h62) ? B1 : ((ch == 8'h65) ? E1 : OTH);
      B1:      r = (ch == 8'h65) ? B2 : OTH;
      B2:      r = (ch == 8'h67) ? B3 : OTH;
      B3:      r = (ch == 8'h69) ? B4 : OTH;
      B4:      r = (ch == 8'h6E) ? B5 : OTH;
      E1:      r = (ch == 8'h6E) ? E2 : OTH;
      E2:      r = (ch == 8'h64) ? E3 : OTH;
      default: r = OTH;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] kind_of(input state_t st);
    logic [1:0] r;
    case (st)
      B5:      r = CODE_BEGIN;
      E3:      r = CODE_END;
      default: r = CODE_OTHER;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  // Handshake and per-character classification.
  always_comb begin
    in_ready_s  = !tok_valid_r || lex.tok_ready;
    accept_s    = lex.in_valid && in_ready_s;
    sep_s       = is_sep(lex.in_data);
    lc_s        = to_lower(lex.in_data);
    adv_state_s = next_word_state(state_r, lc_s);
    adv_len_s   = sat_inc(len_r);
  end

  // Next-state and token-emission decision for the accepted character.
  always_comb begin
    emit_s      = 1'b0;
    emit_code_s = kind_of(state_r);
    emit_len_s  = len_r;
    emit_last_s = 1'b0;
    nxt_state_s = state_r;
    nxt_len_s   = len_r;
    if (accept_s) begin
      if (sep_s) begin
        nxt_state_s = IDLE;
        nxt_len_s   = 8'd0;
        // A separator closes a pending word; in IDLE the last flag is simply dropped.
        if (state_r != IDLE) begin
          emit_s      = 1'b1;
          emit_code_s = kind_of(state_r);
          emit_len_s  = len_r;
          emit_last_s = lex.in_last;
        end else begin
          emit_s      = 1'b0;
        end
      end else if (lex.in_last) begin
        // The final character belongs to the word, so classify the advanced state.
        nxt_state_s = IDLE;
        nxt_len_s   = 8'd0;
        emit_s      = 1'b1;
        emit_code_s = kind_of(adv_state_s);
        emit_len_s  = adv_len_s;
        emit_last_s = 1'b1;
      end else begin
        nxt_state_s = adv_state_s;
        nxt_len_s   = adv_len_s;
      end
    end else begin
      emit_s      = 1'b0;
    end
  end

  // FSM, length counter, token register and emission counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      len_r        <= 8'd0;
      tok_valid_r  <= 1'b0;
      tok_code_r   <= 2'b00;
      tok_len_r    <= 8'd0;
      tok_last_r   <= 1'b0;
      word_count_r <= 16'd0;
    end else begin
      state_r <= nxt_state_s;
      len_r   <= nxt_len_s;
      if (emit_s) begin
        tok_valid_r  <= 1'b1;
        tok_code_r   <= emit_code_s;
        tok_len_r    <= emit_len_s;
        tok_last_r   <= emit_last_s;
        word_count_r <= word_count_r + 16'd1;
      end else if (lex.tok_ready) begin
        tok_valid_r  <= 1'b0;
      end else begin
        tok_valid_r  <= tok_valid_r;
      end
    end
  end

  assign lex.in_ready   = in_ready_s;
  assign lex.tok_valid  = tok_valid_r;
  assign lex.tok_code   = tok_code_r;
  assign lex.tok_len    = tok_len_r;
  assign lex.tok_last   = tok_last_r;
  assign lex.word_count = word_count_r;

endmodule

// File: tb/tb_word_lexer.sv
// Self-checking bench for word_lexer: per-character vector table plus backpressure,
// saturation and mid-word reset sequences.
module tb_word_lexer;

  logic clk;
  logic reset;
  word_lexer_if lex_if ();

  word_lexer dut (
    .clk   (clk),
    .reset (reset),
    .lex   (lex_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       exp_valid;
    logic [1:0] exp_code;
    logic [7:0] exp_len;
    logic       exp_last;
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   bad;
  int   exp_wc;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic l, input logic v,
                              input logic [1:0] c, input logic [7:0] n, input logic lst);
    vec_t r;
    r.data = d; r.last = l; r.exp_valid = v; r.exp_code = c; r.exp_len = n; r.exp_last = lst;
    return r;
  endfunction

  task automatic add_none(input string s);
    for (int i = 0; i < s.len(); i++) vecs.push_back(mk(s[i], 1'b0, 1'b0, 2'b00, 8'd0, 1'b0));
  endtask

  task automatic add_tok(input logic [7:0] d, input logic l, input logic [1:0] c,
                         input logic [7:0] n, input logic lst);
    vecs.push_back(mk(d, l, 1'b1, c, n, lst));
  endtask

  // Drive one character (tok_ready assumed 1), clock it in, and check the outcome.
  task automatic apply(input vec_t v, input string tag);
    lex_if.in_valid = 1'b1;
    lex_if.in_data  = v.data;
    lex_if.in_last  = v.last;
    #1;
    check({tag, " in_ready"}, {15'd0, lex_if.in_ready}, 16'd1);
    @(posedge clk);
    #1;
    check({tag, " tok_valid"}, {15'd0, lex_if.tok_valid}, {15'd0, v.exp_valid});
    if (v.exp_valid) begin
      exp_wc++;
      check({tag, " tok_code"}, {14'd0, lex_if.tok_code}, {14'd0, v.exp_code});
      check({tag, " tok_len"},  {8'd0, lex_if.tok_len},   {8'd0, v.exp_len});
      check({tag, " tok_last"}, {15'd0, lex_if.tok_last}, {15'd0, v.exp_last});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_wc = 0;
    reset = 1'b1;
    lex_if.in_valid  = 1'b0;
    lex_if.in_data   = 8'h00;
    lex_if.in_last   = 1'b0;
    lex_if.tok_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst tok_valid",  {15'd0, lex_if.tok_valid}, 16'd0);
    check("rst tok_code",   {14'd0, lex_if.tok_code},  16'd0);
    check("rst tok_len",    {8'd0, lex_if.tok_len},    16'd0);
    check("rst tok_last",   {15'd0, lex_if.tok_last},  16'd0);
    check("rst word_count", lex_if.word_count,         16'd0);
    check("rst in_ready",   {15'd0, lex_if.in_ready},  16'd1);

    add_none("BeGiN"); add_tok(8'h20, 1'b0, 2'b01, 8'd5, 1'b0);
    add_none("end");   add_tok(8'h20, 1'b0, 2'b10, 8'd3, 1'b0);
    add_none("  beginx"); add_tok(8'h20, 1'b0, 2'b11, 8'd6, 1'b0);
    add_none("be");    add_tok(8'h20, 1'b0, 2'b11, 8'd2, 1'b0);
    add_none("e");     add_tok(8'h20, 1'b0, 2'b11, 8'd1, 1'b0);
    add_none("en");    add_tok("d",   1'b1, 2'b10, 8'd3, 1'b1);
    add_none(" \t");   vecs.push_back(mk(8'h0A, 1'b1, 1'b0, 2'b00, 8'd0, 1'b0));
    add_none("END");   add_tok(8'h09, 1'b0, 2'b10, 8'd3, 1'b0);
    add_none("bex");   add_tok(8'h0D, 1'b0, 2'b11, 8'd3, 1'b0);
    add_none("begins"); add_tok(8'h0A, 1'b0, 2'b11, 8'd6, 1'b0);
    add_none("hi");    add_tok(8'h0D, 1'b1, 2'b11, 8'd2, 1'b1);
    add_tok("a", 1'b1, 2'b11, 8'd1, 1'b1);
    add_tok("b", 1'b1, 2'b11, 8'd1, 1'b1);
    add_none("begi");  add_tok("n",   1'b1, 2'b01, 8'd5, 1'b1);
`ifdef WORD_LEXER_PUNCT_SEP_EN
    add_none("end");   add_tok(";",   1'b0, 2'b10, 8'd3, 1'b0);
    add_none(",be");   add_tok(",",   1'b0, 2'b11, 8'd2, 1'b0);
`else
    add_none("end;");  add_tok(8'h20, 1'b0, 2'b11, 8'd4, 1'b0);
    add_none("a,b");   add_tok(8'h20, 1'b0, 2'b11, 8'd3, 1'b0);
`endif

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));
    lex_if.in_valid = 1'b0;
    lex_if.in_last  = 1'b0;
    check("table word_count", lex_if.word_count, exp_wc[15:0]);
    @(posedge clk);
    #1;
    check("drain tok_valid", {15'd0, lex_if.tok_valid}, 16'd0);

    // Backpressure: "a b " with tok_ready low.
    lex_if.tok_ready = 1'b0;
    lex_if.in_valid  = 1'b1;
    lex_if.in_data   = "a";
    @(posedge clk); #1;
    check("bp a tok_valid", {15'd0, lex_if.tok_valid}, 16'd0);
    lex_if.in_data = 8'h20;
    @(posedge clk); #1;
    exp_wc++;
    check("bp tok_valid", {15'd0, lex_if.tok_valid}, 16'd1);
    lex_if.in_data = "b";
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d in_ready", k),  {15'd0, lex_if.in_ready},  16'd0);
      @(posedge clk); #1;
      check($sformatf("bp%0d tok_valid", k), {15'd0, lex_if.tok_valid}, 16'd1);
      check($sformatf("bp%0d tok_code", k),  {14'd0, lex_if.tok_code},  16'd3);
      check($sformatf("bp%0d tok_len", k),   {8'd0, lex_if.tok_len},    16'd1);
      check($sformatf("bp%0d tok_last", k),  {15'd0, lex_if.tok_last},  16'd0);
    end
    lex_if.tok_ready = 1'b1;
    #1;
    check("bp release in_ready", {15'd0, lex_if.in_ready}, 16'd1);
    @(posedge clk); #1;
    check("bp b tok_valid", {15'd0, lex_if.tok_valid}, 16'd0);
    apply(mk(8'h20, 1'b0, 1'b1, 2'b11, 8'd1, 1'b0), "bp second");

    // Saturation: 300 x's then a space.
    for (int k = 0; k < 300; k++) apply(mk("x", 1'b0, 1'b0, 2'b00, 8'd0, 1'b0), "long x");
    apply(mk(8'h20, 1'b0, 1'b1, 2'b11, 8'd255, 1'b0), "long end");
    lex_if.in_valid = 1'b0;
    check("long word_count", lex_if.word_count, exp_wc[15:0]);

    // Reset mid-word after "beg", then " end ".
    apply(mk("b", 1'b0, 1'b0, 2'b00, 8'd0, 1'b0), "mid b");
    apply(mk("e", 1'b0, 1'b0, 2'b00, 8'd0, 1'b0), "mid e");
    apply(mk("g", 1'b0, 1'b0, 2'b00, 8'd0, 1'b0), "mid g");
    lex_if.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid rst word_count", lex_if.word_count, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_wc = 0;
    @(posedge clk); #1;
    check("mid post tok_valid", {15'd0, lex_if.tok_valid}, 16'd0);
    check("mid post in_ready",  {15'd0, lex_if.in_ready},  16'd1);
    apply(mk(8'h20, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0), "mid sp");
    apply(mk("e", 1'b0, 1'b0, 2'b00, 8'd0, 1'b0), "mid2 e");
    apply(mk("n", 1'b0, 1'b0, 2'b00, 8'd0, 1'b0), "mid2 n");
    apply(mk("d", 1'b0, 1'b0, 2'b00, 8'd0, 1'b0), "mid2 d");
    apply(mk(8'h20, 1'b0, 1'b1, 2'b10, 8'd3, 1'b0), "mid2 end");
    lex_if.in_valid = 1'b0;
    check("mid word_count", lex_if.word_count, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
